// File: rtl/arith_op_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// arith_op_scheduler_pkg
// Shared definitions for the arithmetic-unit scheduler:
//   op_e        request opcodes (ADD, SUB, DIV, reserved)
//   state_e     scheduler FSM state encodings
//   DIV_TIMEOUT_DEFAULT  cycles the scheduler waits for the divider
//   mag_zero()  true when a sign-magnitude value has magnitude 0 (covers 8'h80)
// ---------------------------------------------------------------------------
package arith_op_scheduler_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_DIV = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_DWAIT = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam int DIV_TIMEOUT_DEFAULT = 16;

    // Negative zero (8'h80) has magnitude 0, so only bits 6:0 matter.
    function automatic logic mag_zero(input logic [7:0] v);
        return (v[6:0] == 7'd0);
    endfunction

endpackage

// File: rtl/arith_op_scheduler_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. A lone valid requester always wins; when both
// are valid, the requester named by i_ptr wins.
//   i_valid  [1:0]  request valids (bit N = requester N)
//   i_ptr           preferred requester when both are valid
//   o_grant  [1:0]  one-hot grant (all zero when nobody is valid)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = i_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/arith_op_scheduler.sv
// ---------------------------------------------------------------------------
// arith_op_scheduler
// Shares one adder, one subtractor and one multi-cycle divider between two
// requesters. One operation is in flight at a time; requesters are served
// round-robin and each result returns on a valid/ready channel tagged with
// the requester id.
//   clk, rst                       clock (rising edge), async active-low reset
//   i_reqN_valid/o_reqN_ready      request handshake, N = 0,1
//   i_reqN_op/_a/_b                opcode and sign-magnitude operands
//   o_rsp_valid/i_rsp_ready        response handshake
//   o_rsp_id/_res/_rem/_flag       response payload
//   o_alu_x/o_alu_y                latched operands to adder/subtractor
//   i_add_z/i_add_ovr              adder result and overflow
//   i_sub_b/i_sub_bout             subtractor result and borrow
//   o_div_start/o_div_a/o_div_b    divider start pulse and magnitudes
//   i_div_q/i_div_r/i_div_done     divider quotient, remainder, done pulse
// ---------------------------------------------------------------------------
module arith_op_scheduler
    import arith_op_scheduler_pkg::*;
#(
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    input  logic [1:0] i_req0_op,
    input  logic [7:0] i_req0_a,
    input  logic [7:0] i_req0_b,
    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    input  logic [1:0] i_req1_op,
    input  logic [7:0] i_req1_a,
    input  logic [7:0] i_req1_b,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic       o_rsp_id,
    output logic [7:0] o_rsp_res,
    output logic [7:0] o_rsp_rem,
    output logic       o_rsp_flag,
    output logic [7:0] o_alu_x,
    output logic [7:0] o_alu_y,
    input  logic [7:0] i_add_z,
    input  logic       i_add_ovr,
    input  logic [7:0] i_sub_b,
    input  logic       i_sub_bout,
    output logic       o_div_start,
    output logic [7:0] o_div_a,
    output logic [7:0] o_div_b,
    input  logic [7:0] i_div_q,
    input  logic [7:0] i_div_r,
    input  logic       i_div_done
);

    localparam int CW = $clog2(DIV_TIMEOUT + 1);

    state_e      r_state, w_next;
    logic        r_rr_ptr;
    logic        r_id;
    op_e         r_op;
    logic [7:0]  r_a, r_b;
    logic [7:0]  r_div_a, r_div_b;
    logic [CW-1:0] r_cnt;
    logic [7:0]  r_res, r_rem;
    logic        r_flag;

    logic [1:0]  w_valid, w_grant;
    logic        w_sel;
    logic [1:0]  w_req_op;
    logic [7:0]  w_req_a, w_req_b;
    logic        w_accept, w_div_start, w_load_rsp;
    logic [7:0]  w_res, w_rem;
    logic        w_flag;
    logic        w_unused;

    assign w_valid = {i_req1_valid, i_req0_valid};

    rr_arb2 u_arb (
        .i_valid (w_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    assign w_sel    = w_grant[1];
    assign w_req_op = w_sel ? i_req1_op : i_req0_op;
    assign w_req_a  = w_sel ? i_req1_a  : i_req0_a;
    assign w_req_b  = w_sel ? i_req1_b  : i_req0_b;

    // The divider only produces 7-bit magnitudes; its top bits carry nothing.
    assign w_unused = ^{i_div_q[7], i_div_r[7]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, handshake strobes and the response value to capture.
    // The divider timeout fires on the DIV_TIMEOUT-th D_WAIT cycle without done.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_div_start = 1'b0;
        w_load_rsp  = 1'b0;
        w_res       = 8'h00;
        w_rem       = 8'h00;
        w_flag      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_grant) begin
                    w_accept = 1'b1;
                    w_next   = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_op)
                    OP_ADD: begin
                        w_load_rsp = 1'b1;
                        w_res      = i_add_z;
                        w_flag     = i_add_ovr;
                        w_next     = S_RESP;
                    end
                    OP_SUB: begin
                        w_load_rsp = 1'b1;
                        w_res      = i_sub_b;
                        w_flag     = i_sub_bout;
                        w_next     = S_RESP;
                    end
                    OP_DIV: begin
                        if (mag_zero(r_b)) begin
                            w_load_rsp = 1'b1;
                            w_flag     = 1'b1;
                            w_next     = S_RESP;
                        end else begin
                            w_div_start = 1'b1;
                            w_next      = S_DWAIT;
                        end
                    end
                    default: begin
                        w_load_rsp = 1'b1;
                        w_flag     = 1'b1;
                        w_next     = S_RESP;
                    end
                endcase
            end
            S_DWAIT: begin
                if (i_div_done) begin
                    // A zero quotient or remainder never carries a minus sign.
                    w_load_rsp = 1'b1;
                    w_res      = {(r_a[7] ^ r_b[7]) & (i_div_q[6:0] != 7'd0), i_div_q[6:0]};
                    w_rem      = {r_a[7] & (i_div_r[6:0] != 7'd0), i_div_r[6:0]};
                    w_next     = S_RESP;
                end else if (r_cnt == CW'(DIV_TIMEOUT - 1)) begin
                    w_load_rsp = 1'b1;
                    w_flag     = 1'b1;
                    w_next     = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, divider operands, timeout counter, response payload and
    // the round-robin pointer, which favours the other requester after a reply.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= 1'b0;
            r_id     <= 1'b0;
            r_op     <= OP_ADD;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_div_a  <= 8'h00;
            r_div_b  <= 8'h00;
            r_cnt    <= '0;
            r_res    <= 8'h00;
            r_rem    <= 8'h00;
            r_flag   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id <= w_sel;
                r_op <= op_e'(w_req_op);
                r_a  <= w_req_a;
                r_b  <= w_req_b;
                if (w_req_op == OP_DIV) begin
                    r_div_a <= {1'b0, w_req_a[6:0]};
                    r_div_b <= {1'b0, w_req_b[6:0]};
                end
            end
            if (w_div_start) begin
                r_cnt <= '0;
            end else if (r_state == S_DWAIT) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_load_rsp) begin
                r_res  <= w_res;
                r_rem  <= w_rem;
                r_flag <= w_flag;
            end
            if (r_state == S_RESP && i_rsp_ready) begin
                r_rr_ptr <= ~r_id;
            end
        end
    end

    assign o_req0_ready = (r_state == S_IDLE) & w_grant[0];
    assign o_req1_ready = (r_state == S_IDLE) & w_grant[1];
    assign o_rsp_valid  = (r_state == S_RESP);
    assign o_rsp_id     = r_id;
    assign o_rsp_res    = r_res;
    assign o_rsp_rem    = r_rem;
    assign o_rsp_flag   = r_flag;
    assign o_alu_x      = r_a;
    assign o_alu_y      = r_b;
    assign o_div_start  = w_div_start;
    assign o_div_a      = r_div_a;
    assign o_div_b      = r_div_b;

endmodule

// File: tb/tb_arith_op_scheduler.sv
// ---------------------------------------------------------------------------
// tb_arith_op_scheduler
// Drives the scheduler from two requesters, models the adder, subtractor
// and divider around it, and scores every response against expected values
// queued per requester when each request is issued.
// ---------------------------------------------------------------------------
module tb_arith_op_scheduler;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] rem;
        logic       flag;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_flag;
    logic [7:0] rsp_res, rsp_rem;
    logic [7:0] alu_x, alu_y, add_z, sub_b;
    logic       add_ovr, sub_bout;
    logic       div_start, div_done;
    logic [7:0] div_a, div_b, div_q, div_r;

    int   checks = 0;
    int   errors = 0;
    int   n_start = 0;
    int   div_lat = 4;
    rsp_t q0[$];
    rsp_t q1[$];
    logic id_log[$];

    arith_op_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .i_req0_valid (req0_valid),
        .o_req0_ready (req0_ready),
        .i_req0_op    (req0_op),
        .i_req0_a     (req0_a),
        .i_req0_b     (req0_b),
        .i_req1_valid (req1_valid),
        .o_req1_ready (req1_ready),
        .i_req1_op    (req1_op),
        .i_req1_a     (req1_a),
        .i_req1_b     (req1_b),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_res    (rsp_res),
        .o_rsp_rem    (rsp_rem),
        .o_rsp_flag   (rsp_flag),
        .o_alu_x      (alu_x),
        .o_alu_y      (alu_y),
        .i_add_z      (add_z),
        .i_add_ovr    (add_ovr),
        .i_sub_b      (sub_b),
        .i_sub_bout   (sub_bout),
        .o_div_start  (div_start),
        .o_div_a      (div_a),
        .o_div_b      (div_b),
        .i_div_q      (div_q),
        .i_div_r      (div_r),
        .i_div_done   (div_done)
    );

    always #5 clk = ~clk;

    // Combinational adder (carry out as overflow) and subtractor (borrow).
    assign {add_ovr, add_z} = {1'b0, alu_x} + {1'b0, alu_y};
    assign sub_b            = alu_x - alu_y;
    assign sub_bout         = (alu_x < alu_y);

    // Divider: done pulses div_lat cycles after start; div_lat=0 never answers.
    int         d_cnt;
    logic       d_busy;
    logic [7:0] d_a, d_b;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_busy   <= 1'b0;
            d_cnt    <= 0;
            d_a      <= 8'h00;
            d_b      <= 8'h01;
            div_done <= 1'b0;
            div_q    <= 8'h00;
            div_r    <= 8'h00;
        end else begin
            div_done <= 1'b0;
            if (div_start) begin
                d_busy <= 1'b1;
                d_cnt  <= div_lat;
                d_a    <= div_a;
                d_b    <= div_b;
            end else if (d_busy && d_cnt == 1) begin
                d_busy   <= 1'b0;
                div_done <= 1'b1;
                div_q    <= d_a / d_b;
                div_r    <= d_a % d_b;
            end else if (d_busy && d_cnt > 1) begin
                d_cnt <= d_cnt - 1;
            end
        end
    end

    // Response monitor: pops the scoreboard of the tagged requester on each
    // handshake and also counts divider start pulses.
    rsp_t m_exp;
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            checks++;
            if ((rsp_id ? q1.size() : q0.size()) == 0) begin
                errors++;
                $display("[TB] FAIL rsp_unexpected: got response id=%0d, required none pending", rsp_id);
            end else begin
                m_exp = rsp_id ? q1.pop_front() : q0.pop_front();
                if ({rsp_res, rsp_rem, rsp_flag} !== m_exp) begin
                    errors++;
                    $display("[TB] FAIL rsp_data id=%0d: got res=%h rem=%h flag=%b, required res=%h rem=%h flag=%b",
                             rsp_id, rsp_res, rsp_rem, rsp_flag, m_exp.res, m_exp.rem, m_exp.flag);
                end
            end
            id_log.push_back(rsp_id);
        end
        if (rst && div_start) n_start++;
    end

    // Reference behaviour of one operation on sign-magnitude operands.
    function automatic rsp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        rsp_t       e;
        logic [8:0] s;
        logic [6:0] qm, rm;
        e = '0;
        case (op)
            2'b00: begin
                s      = {1'b0, a} + {1'b0, b};
                e.res  = s[7:0];
                e.flag = s[8];
            end
            2'b01: begin
                e.res  = a - b;
                e.flag = (a < b);
            end
            2'b10: begin
                if (b[6:0] == 7'd0) begin
                    e.flag = 1'b1;
                end else begin
                    qm    = a[6:0] / b[6:0];
                    rm    = a[6:0] % b[6:0];
                    e.res = {(a[7] ^ b[7]) & (qm != 7'd0), qm};
                    e.rem = {a[7] & (rm != 7'd0), rm};
                end
            end
            default: e.flag = 1'b1;
        endcase
        return e;
    endfunction

    // Presents one request on a port, queues its expected response, and
    // returns just after the accepting clock edge.
    task automatic issue(input int port, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input rsp_t e);
        logic ok;
        ok = 1'b0;
        if (port == 0) begin
            q0.push_back(e);
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            q1.push_back(e);
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL accept_timeout port=%0d: accepted=0, required 1", port);
        end
    endtask

    task automatic wait_drained(input string name);
        for (int k = 0; k < 400 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: pending=%0d, required 0", name, q0.size() + q1.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Everything visible must be zero while reset is held.
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_valid, req0_ready, req1_ready, div_start} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, required 0000", {rsp_valid, req0_ready, req1_ready, div_start});
        end
        checks++;
        if ({rsp_res, rsp_rem, rsp_flag, rsp_id} !== 18'h0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got %h, required 0", {rsp_res, rsp_rem, rsp_flag, rsp_id});
        end
        checks++;
        if ({alu_x, alu_y, div_a, div_b} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_operands: got %h, required 0", {alu_x, alu_y, div_a, div_b});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ADD 5+3 with the response expected two cycles after acceptance.
    task automatic test_add_latency();
        rsp_ready = 1'b1;
        issue(0, 2'b00, 8'd5, 8'd3, model(2'b00, 8'd5, 8'd3));
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_latency_t1: rsp_valid=%b, required 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_latency_t2: rsp_valid=%b id=%b, required 1 0", rsp_valid, rsp_id);
        end
        wait_drained("add");
    endtask

    task automatic test_patterns();
        issue(0, 2'b01, 8'd20,  8'd7,   model(2'b01, 8'd20,  8'd7));
        issue(1, 2'b01, 8'd3,   8'd9,   model(2'b01, 8'd3,   8'd9));
        issue(0, 2'b00, 8'd200, 8'd100, model(2'b00, 8'd200, 8'd100));
        issue(1, 2'b11, 8'h12,  8'h34,  model(2'b11, 8'h12,  8'h34));
        wait_drained("patterns");
    endtask

    // Signed division: exactly one start pulse per real division.
    task automatic test_div();
        n_start = 0;
        issue(0, 2'b10, 8'h0A, 8'h83, model(2'b10, 8'h0A, 8'h83));
        wait_drained("div_a");
        checks++;
        if (n_start != 1) begin
            errors++;
            $display("[TB] FAIL div_start_count: got %0d, required 1", n_start);
        end
        issue(1, 2'b10, 8'h87, 8'h02, model(2'b10, 8'h87, 8'h02));
        issue(0, 2'b10, 8'h83, 8'h05, model(2'b10, 8'h83, 8'h05));
        wait_drained("div_b");
    endtask

    task automatic test_div_zero();
        n_start = 0;
        issue(1, 2'b10, 8'd7,  8'h00, '{res: 8'h00, rem: 8'h00, flag: 1'b1});
        issue(0, 2'b10, 8'h85, 8'h80, '{res: 8'h00, rem: 8'h00, flag: 1'b1});
        wait_drained("div_zero");
        checks++;
        if (n_start != 0) begin
            errors++;
            $display("[TB] FAIL div_zero_start: got %0d pulses, required 0", n_start);
        end
    endtask

    task automatic test_div_timeout();
        div_lat = 0;
        issue(0, 2'b10, 8'd9, 8'd2, '{res: 8'h00, rem: 8'h00, flag: 1'b1});
        wait_drained("div_timeout");
        div_lat = 4;
    endtask

    // Reset during D_WAIT discards the op; the next request is served.
    task automatic test_reset_mid_div();
        logic seen;
        div_lat = 0;
        issue(0, 2'b10, 8'd10, 8'd3, model(2'b10, 8'd10, 8'd3));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        @(negedge clk);
        checks++;
        if ({rsp_valid, div_start} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got %b, required 00", {rsp_valid, div_start});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_rsp: rsp_valid seen=%b, required 0", seen);
        end
        div_lat = 4;
        issue(0, 2'b00, 8'd1, 8'd2, model(2'b00, 8'd1, 8'd2));
        wait_drained("after_reset");
    endtask

    // Both requesters busy from a fresh reset: grants alternate 0,1,0,1...
    task automatic test_back_to_back();
        pulse_reset();
        id_log.delete();
        fork
            begin
                issue(0, 2'b00, 8'd1,  8'd1,  model(2'b00, 8'd1,  8'd1));
                issue(0, 2'b01, 8'd9,  8'd4,  model(2'b01, 8'd9,  8'd4));
                issue(0, 2'b10, 8'h0A, 8'h03, model(2'b10, 8'h0A, 8'h03));
                issue(0, 2'b00, 8'h10, 8'h20, model(2'b00, 8'h10, 8'h20));
            end
            begin
                issue(1, 2'b01, 8'd5,  8'd6,  model(2'b01, 8'd5,  8'd6));
                issue(1, 2'b00, 8'd7,  8'd8,  model(2'b00, 8'd7,  8'd8));
                issue(1, 2'b10, 8'h8F, 8'h04, model(2'b10, 8'h8F, 8'h04));
                issue(1, 2'b11, 8'h01, 8'h01, model(2'b11, 8'h01, 8'h01));
            end
        join
        wait_drained("b2b");
        checks++;
        if (id_log.size() != 8) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d responses, required 8", id_log.size());
        end
        for (int i = 0; i < id_log.size(); i++) begin
            checks++;
            if (id_log[i] !== i[0]) begin
                errors++;
                $display("[TB] FAIL b2b_order[%0d]: got id=%b, required %b", i, id_log[i], i[0]);
            end
        end
    endtask

    // Consumer stalls 5 cycles: payload holds and no request is accepted.
    task automatic test_stall();
        rsp_ready = 1'b0;
        issue(0, 2'b00, 8'h11, 8'h22, model(2'b00, 8'h11, 8'h22));
        fork
            issue(1, 2'b01, 8'h30, 8'h10, model(2'b01, 8'h30, 8'h10));
        join_none
        for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_res, rsp_rem, rsp_flag} !== {1'b1, 1'b0, 8'h33, 8'h00, 1'b0}) begin
                errors++;
                $display("[TB] FAIL stall_hold: got valid=%b id=%b res=%h rem=%h flag=%b, required 1 0 33 00 0",
                         rsp_valid, rsp_id, rsp_res, rsp_rem, rsp_flag);
            end
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL stall_ready: got %b, required 00", {req0_ready, req1_ready});
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_drained("stall");
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_patterns();
        test_div();
        test_div_zero();
        test_div_timeout();
        test_reset_mid_div();
        test_back_to_back();
        test_stall();
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
